// File: rtl/bus_valve_ctrl.sv
// bus_valve_ctrl
//   Watches a master/slave command-response bus and decides when the bus
//   valve may isolate the slave side. Accepted reads are counted until their
//   responses are accepted; a close request first stalls new commands (DRAIN)
//   and only closes the valve once nothing is outstanding or the drain
//   timeout expires.
//
// Ports
//   clk           single clock, rising edge
//   reset         synchronous, active-high
//   close_req     level request to isolate the slave side
//   mcmd          observed MCmd (IDLE=0, WRITE=1, READ=2)
//   scmd_accept   observed SCmdAccept
//   sresp         observed SResp (NULL=0)
//   mresp_accept  observed MRespAccept
//   cmd_block     stall new commands at the upstream gate
//   close         close input of the bus valve
//   state         OPEN=0, DRAIN=1, CLOSED=2
//   outstanding   accepted reads still awaiting a response
//   timeout       sticky: last close was forced by the drain timeout
//   err           sticky: outstanding counter overflow/underflow
//
// state  | meaning
// OPEN   | traffic flows, reads and responses are counted
// DRAIN  | new commands stalled, waiting for outstanding reads to finish
// CLOSED | valve closed, counters frozen at zero
module bus_valve_ctrl #(
  parameter int MAX_OUTSTANDING = 8,
  parameter int DRAIN_TIMEOUT   = 1024
) (
  input  logic                                     clk,
  input  logic                                     reset,
  input  logic                                     close_req,
  input  logic [2:0]                               mcmd,
  input  logic                                     scmd_accept,
  input  logic [1:0]                               sresp,
  input  logic                                     mresp_accept,
  output logic                                     cmd_block,
  output logic                                     close,
  output logic [1:0]                               state,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0]     outstanding,
  output logic                                     timeout,
  output logic                                     err
);

  localparam int OW = $clog2(MAX_OUTSTANDING + 1);
  localparam int TW = (DRAIN_TIMEOUT > 1) ? $clog2(DRAIN_TIMEOUT) : 1;
  localparam bit TIMEOUT_EN = (DRAIN_TIMEOUT > 0);
  localparam logic [OW-1:0] OUT_MAX = OW'(MAX_OUTSTANDING);
  // Counter value seen during the last permitted DRAIN cycle.
  localparam logic [TW-1:0] T_LAST = TW'((DRAIN_TIMEOUT > 0) ? DRAIN_TIMEOUT - 1 : 0);

  localparam logic [2:0] CMD_READ  = 3'd2;
  localparam logic [1:0] RESP_NULL = 2'd0;

  typedef enum logic [1:0] {
    ST_OPEN   = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_CLOSED = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [OW-1:0]   out_q, out_d;
  logic [TW-1:0]   drain_cnt;
  logic            timeout_q, timeout_d;
  logic            err_q, err_d;

  logic rd_acc, rsp_acc, counting, ovf, unf, timeout_hit;

  assign rd_acc  = (mcmd == CMD_READ) && scmd_accept;
  assign rsp_acc = (sresp != RESP_NULL) && mresp_accept;

  assign counting = (state_q != ST_CLOSED);
  assign ovf = counting && rd_acc && !rsp_acc && (out_q == OUT_MAX);
  assign unf = counting && rsp_acc && !rd_acc && (out_q == '0);

  // Drain completion wins over the timeout when both land in the same cycle,
  // so the timeout flag only reports closes that abandoned live reads.
  assign timeout_hit = TIMEOUT_EN && (state_q == ST_DRAIN) && close_req &&
                       (out_q != '0) && (drain_cnt == T_LAST);

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_OPEN: begin
        if (close_req) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (!close_req)       state_d = ST_OPEN;
        else if (out_q == '0) state_d = ST_CLOSED;
        else if (timeout_hit) state_d = ST_CLOSED;
      end
      ST_CLOSED: begin
        if (!close_req) state_d = ST_OPEN;
      end
      default: state_d = ST_OPEN;
    endcase
  end

  always_comb begin
    out_d = out_q;
    if (state_d == ST_CLOSED) begin
      out_d = '0;
    end else if (counting) begin
      if (rd_acc && !rsp_acc && !ovf)      out_d = out_q + 1'b1;
      else if (rsp_acc && !rd_acc && !unf) out_d = out_q - 1'b1;
    end
  end

  always_comb begin
    timeout_d = timeout_q;
    if (timeout_hit)                                   timeout_d = 1'b1;
    else if (state_q == ST_CLOSED && state_d == ST_OPEN) timeout_d = 1'b0;
  end

  assign err_d = err_q | ovf | unf;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_OPEN;
      out_q     <= '0;
      timeout_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      out_q     <= out_d;
      timeout_q <= timeout_d;
      err_q     <= err_d;
    end
  end

  // Restarts from zero every time DRAIN is entered because it is held at
  // zero in every other state.
  always_ff @(posedge clk) begin
    if (reset)
      drain_cnt <= '0;
    else if (TIMEOUT_EN && state_q == ST_DRAIN)
      drain_cnt <= drain_cnt + 1'b1;
    else
      drain_cnt <= '0;
  end

  assign state       = state_q;
  assign cmd_block   = (state_q != ST_OPEN);
  assign close       = (state_q == ST_CLOSED);
  assign outstanding = out_q;
  assign timeout     = timeout_q;
  assign err         = err_q;

endmodule

// File: tb/tb_bus_valve_ctrl.sv
// Directed bench for bus_valve_ctrl (MAX_OUTSTANDING=8, DRAIN_TIMEOUT=16).
// Table rows give inputs for one cycle and the outputs expected after the
// following rising edge; hand sequences cover the timeout and reset corners.
module tb_bus_valve_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       close_req = 1'b0;
  logic [2:0] mcmd = 3'd0;
  logic       scmd_accept = 1'b0;
  logic [1:0] sresp = 2'd0;
  logic       mresp_accept = 1'b0;
  logic       cmd_block, close, timeout, err;
  logic [1:0] state;
  logic [3:0] outstanding;

  int checks = 0;
  int errors = 0;

  bus_valve_ctrl #(.MAX_OUTSTANDING(8), .DRAIN_TIMEOUT(16)) dut (
    .clk(clk), .reset(reset), .close_req(close_req), .mcmd(mcmd),
    .scmd_accept(scmd_accept), .sresp(sresp), .mresp_accept(mresp_accept),
    .cmd_block(cmd_block), .close(close), .state(state),
    .outstanding(outstanding), .timeout(timeout), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       creq;
    logic [2:0] mc;
    logic       sa;
    logic [1:0] sr;
    logic       ma;
    logic [1:0] e_st;
    logic [3:0] e_out;
    logic       e_cb, e_cl, e_to, e_err;
  } vec_t;

  vec_t vecs[$];

  task automatic v(input logic rst, input logic creq, input logic [2:0] mc, input logic sa,
                   input logic [1:0] sr, input logic ma, input logic [1:0] est, input logic [3:0] eout,
                   input logic ecb, input logic ecl, input logic eto, input logic eerr);
    vec_t t;
    t.rst = rst; t.creq = creq; t.mc = mc; t.sa = sa; t.sr = sr; t.ma = ma;
    t.e_st = est; t.e_out = eout; t.e_cb = ecb; t.e_cl = ecl; t.e_to = eto; t.e_err = eerr;
    vecs.push_back(t);
  endtask

  task automatic drive(input logic rst, input logic creq, input logic [2:0] mc, input logic sa,
                       input logic [1:0] sr, input logic ma);
    @(negedge clk);
    reset = rst; close_req = creq; mcmd = mc; scmd_accept = sa; sresp = sr; mresp_accept = ma;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [1:0] est, input logic [3:0] eout,
                       input logic ecb, input logic ecl, input logic eto, input logic eerr);
    logic [9:0] act, exp;
    act = {state, outstanding, cmd_block, close, timeout, err};
    exp = {est, eout, ecb, ecl, eto, eerr};
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got st=%0d out=%0d cb=%0b cl=%0b to=%0b err=%0b, want st=%0d out=%0d cb=%0b cl=%0b to=%0b err=%0b",
               name, state, outstanding, cmd_block, close, timeout, err,
               est, eout, ecb, ecl, eto, eerr);
    end
  endtask

  localparam logic [2:0] I = 3'd0, W = 3'd1, R = 3'd2;

  initial begin
    int n;
    // rst creq mcmd sa sr ma | st out cb cl to err
    v(1, 0, I, 0, 0, 0,  0, 0, 0, 0, 0, 0);  // 0  reset
    v(0, 0, R, 1, 0, 0,  0, 1, 0, 0, 0, 0);  // 1  three reads
    v(0, 0, R, 1, 0, 0,  0, 2, 0, 0, 0, 0);
    v(0, 0, R, 1, 0, 0,  0, 3, 0, 0, 0, 0);
    v(0, 1, I, 0, 0, 0,  1, 3, 1, 0, 0, 0);  // 4  close_req -> DRAIN, block
    v(0, 1, I, 0, 1, 1,  1, 2, 1, 0, 0, 0);  // 5  responses 2 cycles apart
    v(0, 1, I, 0, 0, 0,  1, 2, 1, 0, 0, 0);
    v(0, 1, I, 0, 1, 1,  1, 1, 1, 0, 0, 0);
    v(0, 1, I, 0, 0, 0,  1, 1, 1, 0, 0, 0);
    v(0, 1, I, 0, 1, 1,  1, 0, 1, 0, 0, 0);  // 9  count reaches 0
    v(0, 1, I, 0, 0, 0,  2, 0, 1, 1, 0, 0);  // 10 close one cycle later
    v(0, 1, R, 1, 1, 1,  2, 0, 1, 1, 0, 0);  // 11 traffic ignored in CLOSED
    v(0, 0, I, 0, 0, 0,  0, 0, 0, 0, 0, 0);  // 12 reopen
    v(0, 0, R, 1, 0, 0,  0, 1, 0, 0, 0, 0);
    v(0, 0, R, 1, 0, 0,  0, 2, 0, 0, 0, 0);
    v(0, 0, R, 1, 1, 1,  0, 2, 0, 0, 0, 0);  // 15 read+resp same cycle
    v(0, 0, R, 1, 0, 0,  0, 3, 0, 0, 0, 0);  // 16..24 nine reads
    v(0, 0, R, 1, 0, 0,  0, 4, 0, 0, 0, 0);
    v(0, 0, R, 1, 0, 0,  0, 5, 0, 0, 0, 0);
    v(0, 0, R, 1, 0, 0,  0, 6, 0, 0, 0, 0);
    v(0, 0, R, 1, 0, 0,  0, 7, 0, 0, 0, 0);
    v(0, 0, R, 1, 0, 0,  0, 8, 0, 0, 0, 0);
    v(0, 0, R, 1, 0, 0,  0, 8, 0, 0, 0, 1);  // 22 overflow saturates
    v(0, 0, R, 1, 0, 0,  0, 8, 0, 0, 0, 1);
    v(0, 0, R, 1, 0, 0,  0, 8, 0, 0, 0, 1);
    v(1, 0, I, 0, 0, 0,  0, 0, 0, 0, 0, 0);  // 25 reset clears err
    v(0, 0, I, 0, 2, 1,  0, 0, 0, 0, 0, 1);  // 26 underflow
    v(0, 1, I, 0, 0, 0,  1, 0, 1, 0, 0, 1);  // 27 DRAIN with 0
    v(0, 1, I, 0, 0, 0,  2, 0, 1, 1, 0, 1);  // 28 CLOSED two edges later
    v(1, 1, I, 0, 0, 0,  0, 0, 0, 0, 0, 0);  // 29 reset in CLOSED, err=1
    v(0, 0, R, 1, 0, 0,  0, 1, 0, 0, 0, 0);
    v(0, 1, I, 0, 0, 0,  1, 1, 1, 0, 0, 0);  // 31 DRAIN, 1 outstanding
    v(0, 0, I, 0, 0, 0,  0, 1, 0, 0, 0, 0);  // 32 drop -> OPEN, count kept
    v(0, 1, I, 0, 0, 0,  1, 1, 1, 0, 0, 0);  // 33 one-cycle pulse
    v(0, 0, I, 0, 0, 0,  0, 1, 0, 0, 0, 0);
    v(0, 0, W, 1, 0, 0,  0, 1, 0, 0, 0, 0);  // 35 writes not counted
    v(0, 0, R, 0, 0, 0,  0, 1, 0, 0, 0, 0);  // 36 read not accepted
    v(0, 0, I, 0, 1, 0,  0, 1, 0, 0, 0, 0);  // 37 resp not accepted

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].creq, vecs[i].mc, vecs[i].sa, vecs[i].sr, vecs[i].ma);
      check($sformatf("vec%0d", i), vecs[i].e_st, vecs[i].e_out,
            vecs[i].e_cb, vecs[i].e_cl, vecs[i].e_to, vecs[i].e_err);
    end

    // Short drain abandoned, so the next drain must start its count afresh.
    for (int i = 0; i < 5; i++) drive(0, 1, I, 0, 0, 0);
    check("short_drain", 2'd1, 4'd1, 1, 0, 0, 0);
    drive(0, 0, I, 0, 0, 0);
    check("short_drain_exit", 2'd0, 4'd1, 0, 0, 0, 0);

    // Drain timeout with one read never answered.
    n = 0;
    for (int i = 0; i < 40; i++) begin
      drive(0, 1, I, 0, 0, 0);
      if (state != 2'd1) break;
      n++;
    end
    checks++;
    if (n != 16) begin
      errors++;
      $display("FAIL drain_cycles: got %0d, want 16", n);
    end
    check("timeout_closed", 2'd2, 4'd0, 1, 1, 1, 0);
    drive(0, 1, I, 0, 0, 0);
    check("timeout_sticky", 2'd2, 4'd0, 1, 1, 1, 0);
    drive(0, 0, I, 0, 0, 0);
    check("timeout_clear", 2'd0, 4'd0, 0, 0, 0, 0);

    // Reset mid-DRAIN with a nonzero count.
    drive(0, 0, R, 1, 0, 0);
    drive(0, 1, R, 1, 0, 0);
    check("pre_reset_drain", 2'd1, 4'd2, 1, 0, 0, 0);
    drive(1, 1, R, 1, 0, 0);
    check("reset_in_drain", 2'd0, 4'd0, 0, 0, 0, 0);
    drive(0, 0, I, 0, 0, 0);
    check("after_reset", 2'd0, 4'd0, 0, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
